// File: rtl/conv_mac_engine_pkg.sv
// Shared definitions for the convolution MAC engine: default widths,
// controller-side FSM encoding, int8 saturation bounds and the rounding helper.
package conv_mac_engine_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ACC_W  = 32;
  localparam int unsigned DEF_ADDR_W = 16;

  localparam int SAT_MAX = 127;
  localparam int SAT_MIN = -128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Half-LSB of the post-shift result; zero when no shift is applied.
  function automatic int unsigned round_const(input int unsigned sh);
    if (sh == 0) return 0;
    return 32'd1 << (sh - 1);
  endfunction

endpackage

// File: rtl/conv_mac_engine_requant.sv
// conv_requant: combinational bias-add, round, arithmetic shift and int8
// saturation of a finished accumulator. Optional ReLU clamp under the
// CONV_MAC_RELU_EN macro.
module conv_requant
  import conv_mac_engine_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned ACC_W      = DEF_ACC_W,
  parameter int unsigned BIAS_SHIFT = 0,
  parameter int unsigned OUT_SHIFT  = 9
) (
  input  logic signed [ACC_W-1:0]  i_acc,
  input  logic        [DATA_W-1:0] i_bias,
  output logic        [DATA_W-1:0] o_res
);

  // Two guard bits keep the bias and rounding additions from wrapping.
  localparam int unsigned EXT_W = ACC_W + BIAS_SHIFT + 2;
  localparam logic signed [EXT_W-1:0] ROUND = EXT_W'(round_const(OUT_SHIFT));
  localparam logic signed [EXT_W-1:0] HI    = EXT_W'(SAT_MAX);
  localparam logic signed [EXT_W-1:0] LO    = EXT_W'(SAT_MIN);

  logic signed [EXT_W-1:0] w_acc_x;
  logic signed [EXT_W-1:0] w_bias_x;
  logic signed [EXT_W-1:0] w_sum;
  logic signed [EXT_W-1:0] w_shr;
  logic        [DATA_W-1:0] w_sat;

  assign w_acc_x  = {{(EXT_W-ACC_W){i_acc[ACC_W-1]}}, i_acc};
  assign w_bias_x = {{(EXT_W-DATA_W){i_bias[DATA_W-1]}}, i_bias} <<< BIAS_SHIFT;
  assign w_sum    = w_acc_x + w_bias_x + ROUND;
  assign w_shr    = w_sum >>> OUT_SHIFT;

  // Saturate the shifted sum into the signed output range, then optional ReLU.
  always_comb begin
    w_sat = w_shr[DATA_W-1:0];
    if (w_shr > HI) begin
      w_sat = HI[DATA_W-1:0];
    end else if (w_shr < LO) begin
      w_sat = LO[DATA_W-1:0];
    end
`ifdef CONV_MAC_RELU_EN
    if (w_sat[DATA_W-1]) begin
      w_sat = '0;
    end
`else
    w_sat = w_sat;
`endif
  end

  assign o_res = w_sat;

endmodule

// File: rtl/conv_mac_engine.sv
// conv_mac_engine: datapath responder to the convolution controller.
// Issues image/weight/bias reads, multiplies int8 operands into a 32-bit
// accumulator, requantises each closed window and writes it to output memory.
// Build option: CONV_MAC_RELU_EN fuses a ReLU clamp into the write value.
module conv_mac_engine
  import conv_mac_engine_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned ACC_W      = DEF_ACC_W,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned BIAS_SHIFT = 0,
  parameter int unsigned OUT_SHIFT  = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_ctrl,
  input  logic              en_read,
  input  logic              en_mac,
  input  logic              en_sat,
  input  logic              en_write,
  input  logic              finish,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [ADDR_W-1:0] save_addr,
  output logic              img_rd_en,
  output logic [ADDR_W-1:0] img_rd_addr,
  input  logic [DATA_W-1:0] img_rd_data,
  output logic              wgt_rd_en,
  output logic [ADDR_W-1:0] wgt_rd_addr,
  input  logic [DATA_W-1:0] wgt_rd_data,
  output logic              bias_rd_en,
  output logic [ADDR_W-1:0] bias_rd_addr,
  input  logic [DATA_W-1:0] bias_rd_data,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_count,
  output logic              busy,
  output logic              done
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  state_t                    r_state;
  logic                      r_busy;
  logic                      r_done;
  logic signed [ACC_W-1:0]   r_prod_q;
  logic                      r_prod_v;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [ACC_W-1:0]   r_acc_fin;
  logic                      r_sat_v;
  logic                      r_wr_pend;
  logic        [DATA_W-1:0]  r_out_data;
  logic        [ADDR_W-1:0]  r_out_addr;
  logic        [ADDR_W-1:0]  r_out_count;

  logic signed [PROD_W-1:0]  w_prod_full;
  logic signed [ACC_W-1:0]   w_prod_x;
  logic        [DATA_W-1:0]  w_res;
  logic                      w_live;
  logic                      w_out_we;
  logic                      w_capture;
  logic                      w_drained;

  assign w_live      = en_ctrl & ~reset;
  assign w_prod_full = $signed(img_rd_data) * $signed(wgt_rd_data);
  assign w_prod_x    = {{(ACC_W-PROD_W){w_prod_full[PROD_W-1]}}, w_prod_full};
  assign w_out_we    = r_wr_pend & w_live;
  assign w_capture   = r_sat_v & en_write;
  // Final write may issue in the same cycle the FSM leaves FLUSH.
  assign w_drained   = ~en_sat & ~r_sat_v & (~r_wr_pend | w_out_we);

  assign img_rd_en    = en_read & w_live;
  assign wgt_rd_en    = en_read & w_live;
  assign img_rd_addr  = s_addr;
  assign wgt_rd_addr  = w_addr;
  assign bias_rd_en   = en_sat & w_live;
  assign bias_rd_addr = b_addr;
  assign out_we       = w_out_we;
  assign out_addr     = r_out_addr;
  assign out_data     = r_out_data;
  assign out_count    = r_out_count;
  assign busy         = r_busy;
  assign done         = r_done;

  conv_requant #(
    .DATA_W     (DATA_W),
    .ACC_W      (ACC_W),
    .BIAS_SHIFT (BIAS_SHIFT),
    .OUT_SHIFT  (OUT_SHIFT)
  ) u_requant (
    .i_acc  (r_acc_fin),
    .i_bias (bias_rd_data),
    .o_res  (w_res)
  );

  // Multiply stage and window accumulator; en_sat hands the total to acc_fin.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prod_q  <= '0;
      r_prod_v  <= 1'b0;
      r_acc     <= '0;
      r_acc_fin <= '0;
      r_sat_v   <= 1'b0;
    end else if (en_ctrl) begin
      r_prod_v <= en_mac;
      if (en_mac) begin
        r_prod_q <= w_prod_x;
      end
      // A product registered at the close still belongs to the closing window.
      if (en_sat) begin
        r_acc_fin <= r_acc + (r_prod_v ? r_prod_q : '0);
        r_acc     <= '0;
      end else if (r_prod_v) begin
        r_acc <= r_acc + r_prod_q;
      end
      r_sat_v <= en_sat;
    end
  end

  // Requantised result capture, write-pending flag and write counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_data  <= '0;
      r_out_addr  <= '0;
      r_wr_pend   <= 1'b0;
      r_out_count <= '0;
    end else if (en_ctrl) begin
      if (w_capture) begin
        r_out_data <= w_res;
        r_out_addr <= save_addr;
      end
      r_wr_pend <= w_capture;
      if (r_wr_pend) begin
        r_out_count <= r_out_count + ADDR_W'(1);
      end
    end
  end

  // Run/flush/done sequencing with registered busy and done.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (en_ctrl) begin
      case (r_state)
        ST_IDLE: begin
          if (finish) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else if (en_read || en_sat) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (finish) begin
            r_state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (w_drained) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_mac_engine.sv
// Self-checking bench for conv_mac_engine: two instances (OUT_SHIFT 0 and 9)
// share stimulus and memories; a window-level reference model predicts writes.
module tb_conv_mac_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, en_ctrl, en_read, en_mac, en_sat, en_write, finish;
  logic [15:0] s_addr, w_addr, b_addr, save_addr;
  logic [7:0]  img_rd_data = '0, wgt_rd_data = '0, bias_rd_data = '0;

  logic        img_rd_en_0, wgt_rd_en_0, bias_rd_en_0, out_we_0, busy_0, done_0;
  logic [15:0] img_rd_addr_0, wgt_rd_addr_0, bias_rd_addr_0, out_addr_0, out_count_0;
  logic [7:0]  out_data_0;
  logic        img_rd_en_9, wgt_rd_en_9, bias_rd_en_9, out_we_9, busy_9, done_9;
  logic [15:0] img_rd_addr_9, wgt_rd_addr_9, bias_rd_addr_9, out_addr_9, out_count_9;
  logic [7:0]  out_data_9;

  conv_mac_engine #(.BIAS_SHIFT(0), .OUT_SHIFT(0)) u_dut0 (
    .clk(clk), .reset(reset), .en_ctrl(en_ctrl), .en_read(en_read), .en_mac(en_mac),
    .en_sat(en_sat), .en_write(en_write), .finish(finish),
    .s_addr(s_addr), .w_addr(w_addr), .b_addr(b_addr), .save_addr(save_addr),
    .img_rd_en(img_rd_en_0), .img_rd_addr(img_rd_addr_0), .img_rd_data(img_rd_data),
    .wgt_rd_en(wgt_rd_en_0), .wgt_rd_addr(wgt_rd_addr_0), .wgt_rd_data(wgt_rd_data),
    .bias_rd_en(bias_rd_en_0), .bias_rd_addr(bias_rd_addr_0), .bias_rd_data(bias_rd_data),
    .out_we(out_we_0), .out_addr(out_addr_0), .out_data(out_data_0),
    .out_count(out_count_0), .busy(busy_0), .done(done_0));

  conv_mac_engine #(.BIAS_SHIFT(0), .OUT_SHIFT(9)) u_dut9 (
    .clk(clk), .reset(reset), .en_ctrl(en_ctrl), .en_read(en_read), .en_mac(en_mac),
    .en_sat(en_sat), .en_write(en_write), .finish(finish),
    .s_addr(s_addr), .w_addr(w_addr), .b_addr(b_addr), .save_addr(save_addr),
    .img_rd_en(img_rd_en_9), .img_rd_addr(img_rd_addr_9), .img_rd_data(img_rd_data),
    .wgt_rd_en(wgt_rd_en_9), .wgt_rd_addr(wgt_rd_addr_9), .wgt_rd_data(wgt_rd_data),
    .bias_rd_en(bias_rd_en_9), .bias_rd_addr(bias_rd_addr_9), .bias_rd_data(bias_rd_data),
    .out_we(out_we_9), .out_addr(out_addr_9), .out_data(out_data_9),
    .out_count(out_count_9), .busy(busy_9), .done(done_9));

  // Synchronous-read SRAM models, 1-cycle latency, output held when idle.
  logic signed [7:0] img_mem [256];
  logic signed [7:0] wgt_mem [256];
  logic signed [7:0] bias_mem[256];
  always @(posedge clk) begin
    if (img_rd_en_0)  img_rd_data  <= img_mem[img_rd_addr_0[7:0]];
    if (wgt_rd_en_0)  wgt_rd_data  <= wgt_mem[wgt_rd_addr_0[7:0]];
    if (bias_rd_en_0) bias_rd_data <= bias_mem[bias_rd_addr_0[7:0]];
  end

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int unsigned due;
    int          addr;
    int          d0;
    int          d9;
  } wr_t;
  wr_t         exp_q[$];
  longint      m_acc;
  int unsigned ecyc;
  int          m_cnt;
  int          m_last_sa, m_last_wa;

  bit p_rd, p_sat, stray;
  int p_save;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int requant(longint acc, int bias, int sh);
    longint s;
    s = acc + longint'(bias);
    if (sh > 0) s = s + (longint'(1) << (sh - 1));
    s = s >>> sh;
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
`ifdef CONV_MAC_RELU_EN
    if (s < 0) s = 0;
`endif
    return int'(s);
  endfunction

  function automatic longint product(int sa, int wa);
    return longint'(img_mem[sa[7:0]]) * longint'(wgt_mem[wa[7:0]]);
  endfunction

  task automatic monitor();
    bit  exp_we;
    wr_t e;
    if (reset) begin
      check("rst_we", out_we_0, 0);
      exp_q.delete();
      m_acc = 0; m_cnt = 0; m_last_sa = 0; m_last_wa = 0;
      return;
    end
    if (!en_ctrl) begin
      check("frz_outs", {img_rd_en_0, wgt_rd_en_0, bias_rd_en_0, out_we_0}, 0);
      return;
    end
    check("rd_en", {img_rd_en_0, wgt_rd_en_0}, {en_read, en_read});
    if (en_read) check("rd_addr", {img_rd_addr_0, wgt_rd_addr_0}, {s_addr, w_addr});
    check("bias_en", bias_rd_en_0, en_sat);
    if (en_sat) check("bias_addr", bias_rd_addr_0, b_addr);
    check("cnt", out_count_0, m_cnt);
    exp_we = (exp_q.size() > 0) && (exp_q[0].due == ecyc);
    check("we0", out_we_0, exp_we);
    check("we9", out_we_9, exp_we);
    if (exp_we) begin
      e = exp_q.pop_front();
      check("addr", out_addr_0, e.addr);
      check("data0", $signed(out_data_0), e.d0);
      check("data9", $signed(out_data_9), e.d9);
      m_cnt++;
    end
    // Window bookkeeping: a close takes products seen before this cycle.
    if (en_sat) begin
      e.due  = ecyc + 2;
      e.addr = p_save;
      e.d0   = requant(m_acc, int'(bias_mem[b_addr[7:0]]), 0);
      e.d9   = requant(m_acc, int'(bias_mem[b_addr[7:0]]), 9);
      exp_q.push_back(e);
      m_acc = 0;
    end
    if (en_mac) m_acc = m_acc + product(m_last_sa, m_last_wa);
    m_last_sa = int'(s_addr);
    m_last_wa = int'(w_addr);
    ecyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input bit rd, input int sa, input int wa, input bit sat,
                     input int ba, input int sv, input bit fin);
    en_ctrl   = 1'b1;
    en_read   = rd;
    s_addr    = 16'(sa);
    w_addr    = 16'(wa);
    en_mac    = p_rd;
    en_sat    = sat;
    b_addr    = 16'(ba);
    en_write  = p_sat | stray;
    save_addr = p_sat ? 16'(p_save) : (stray ? 16'hBEEF : 16'h0);
    finish    = fin;
    p_rd  = rd;
    p_sat = sat;
    p_save = sv;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Controller stalled: strobes it would drive are held, noise on read/sat.
  task automatic freeze(input int n);
    en_ctrl   = 1'b0;
    en_read   = 1'b1;
    en_sat    = 1'b1;
    finish    = 1'b0;
    en_mac    = p_rd;
    en_write  = p_sat;
    save_addr = p_sat ? 16'(p_save) : 16'h0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic window(input int bs, input int bw, input int n, input int ba, input int sv);
    for (int i = 0; i < n; i++) cyc(1, bs + i, bw + i, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, ba, sv, 0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    en_ctrl = 1'b1; en_read = 0; en_mac = 0; en_sat = 0; en_write = 0; finish = 0;
    s_addr = '0; w_addr = '0; b_addr = '0; save_addr = '0;
    p_rd = 0; p_sat = 0; p_save = 0; stray = 0;
    for (int i = 0; i < n; i++) tick();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      img_mem[i]  = 8'($urandom);
      wgt_mem[i]  = 8'($urandom);
      bias_mem[i] = 8'($urandom);
    end
    img_mem[0] = 3;    wgt_mem[0] = 4;
    img_mem[1] = -2;   wgt_mem[1] = 5;
    img_mem[2] = 7;    wgt_mem[2] = 1;
    bias_mem[0] = 10;  bias_mem[1] = 0;
    img_mem[3] = 100;  wgt_mem[3] = 100;
    img_mem[4] = -100; wgt_mem[4] = 100;
    img_mem[5] = 127;  wgt_mem[5] = 6;
    img_mem[6] = 5;    wgt_mem[6] = 1;
    img_mem[7] = -128; wgt_mem[7] = 6;
    img_mem[8] = -1;   wgt_mem[8] = 1;

    do_reset(2);
    check("rst_busy", busy_0, 0);
    check("rst_done", done_0, 0);
    check("rst_count", out_count_0, 0);
    check("rst_data", out_data_0, 0);
    check("rst_addr", out_addr_0, 0);
    check("rst_we", out_we_0, 0);

    // finish while idle goes straight to a one-cycle done
    cyc(0, 0, 0, 0, 0, 0, 1);
    check("idle_fin_done", done_0, 1);
    check("idle_fin_busy", busy_0, 0);
    idle(1);
    check("idle_fin_done_clr", done_0, 0);

    // single window: 3*4 - 2*5 + 7*1 + 10 = 19
    window(0, 0, 3, 0, 100);
    check("busy_run", busy_0, 1);
    idle(3);

    // saturation both ways, then rounding at OUT_SHIFT=9 (767 -> 1, -769 -> -2)
    window(3, 3, 1, 1, 101);
    window(4, 4, 1, 1, 102);
    window(5, 5, 2, 1, 103);
    window(7, 7, 2, 1, 104);
    idle(3);

    // back-to-back closes two cycles apart; mac coincident with the first close
    cyc(1, 10, 10, 0, 0, 0, 0);
    cyc(1, 11, 11, 0, 0, 0, 0);
    cyc(1, 12, 12, 0, 0, 0, 0);
    cyc(1, 13, 13, 1, 2, 105, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 3, 106, 0);
    idle(4);

    // controller freeze for 3 cycles right after a close
    window(20, 30, 3, 4, 107);
    freeze(3);
    idle(4);

    // en_write with no close in flight must not write
    stray = 1;
    idle(1);
    stray = 0;
    idle(3);

    // randomized windows with random gaps and occasional freezes
    for (int w = 0; w < 40; w++) begin
      int n;
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++)
        cyc(1, $urandom_range(0, 255), $urandom_range(0, 255), 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, $urandom_range(0, 255), $urandom_range(0, 65535), 0);
      if ($urandom_range(0, 3) == 0) freeze($urandom_range(1, 3));
      idle($urandom_range(0, 2));
    end
    idle(4);
    check("rand_drain", exp_q.size(), 0);

    // finish with a write still pending: done one cycle after the last write
    window(40, 40, 2, 5, 200);
    cyc(0, 0, 0, 0, 0, 0, 1);
    check("flush_busy", busy_0, 1);
    check("flush_done", done_0, 0);
    idle(1);
    check("fin_done", done_0, 1);
    check("fin_busy", busy_0, 0);
    idle(1);
    check("fin_done_clr", done_0, 0);
    check("fin_count", out_count_0, m_cnt);

    // reset one cycle after a close discards the pending write
    window(50, 50, 2, 6, 300);
    do_reset(1);
    idle(4);
    check("rst_mid_count", out_count_0, 0);
    check("rst_mid_busy", busy_0, 0);
    check("final_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
